// File: rtl/ram_burst_reader.sv
// Burst read sequencer for a 1-cycle-latency synchronous RAM, streaming words out on valid/ready.
// First word bypasses the 2-entry buffer; issue is credit-limited so landed data always has space.
module ram_burst_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic                  mem_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy
);

    localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
    localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(RAM_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic                  inflight_q;
    logic                  inflight_last_q;
    logic [DATA_WIDTH-1:0] buf_dat_q [2];
    logic                  buf_last_q [2];
    logic                  rd_ptr_q, wr_ptr_q;
    logic [1:0]            count_q;

    logic       pop, issue, bypass, push, buf_pop;
    logic [2:0] occ;

    assign pop  = out_valid && out_ready;
    // Words owed to the consumer after this cycle's pop: stored plus the one still in the RAM pipe.
    assign occ  = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue = !rst && (state_q == S_RUN) && (rem_q != '0) && (occ < 3'd2);

    assign bypass  = inflight_q && (count_q == 2'd0) && pop;
    assign push    = inflight_q && !bypass;
    assign buf_pop = pop && (count_q != 2'd0);

    assign cmd_ready = !rst && (state_q == S_IDLE);
    assign busy      = !rst && (state_q != S_IDLE);
    assign mem_en    = issue;
    assign mem_addr  = rst ? '0 : addr_q;
    assign out_valid = !rst && ((count_q != 2'd0) || inflight_q);

    always_comb begin
        out_data = '0;
        out_last = 1'b0;
        if (!rst) begin
            if (count_q != 2'd0) begin
                out_data = buf_dat_q[rd_ptr_q];
                out_last = buf_last_q[rd_ptr_q];
            end else if (inflight_q) begin
                out_data = mem_rdata;
                out_last = inflight_last_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    rem_d   = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;
                    state_d = (cmd_len == '0) ? S_DRAIN : S_RUN;
                end
            end
            S_RUN: begin
                if (issue) begin
                    addr_d = addr_q + 1'b1;
                    rem_d  = rem_q - 1'b1;
                    if (rem_q == LEN_WIDTH'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!inflight_q && (count_q == 2'd0)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            addr_q          <= '0;
            rem_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            buf_dat_q       <= '{default: '0};
            buf_last_q      <= '{default: 1'b0};
            rd_ptr_q        <= 1'b0;
            wr_ptr_q        <= 1'b0;
            count_q         <= 2'd0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            rem_q           <= rem_d;
            inflight_q      <= issue;
            inflight_last_q <= issue && (rem_q == LEN_WIDTH'(1));
            if (push) begin
                buf_dat_q[wr_ptr_q]  <= mem_rdata;
                buf_last_q[wr_ptr_q] <= inflight_last_q;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (buf_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, buf_pop};
        end
    end

endmodule

// File: tb/tb_ram_burst_reader.sv
// Randomized bench for ram_burst_reader: RAM model plus a per-burst expected word list from addr/len arithmetic.
module tb_ram_burst_reader;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int LW = 9;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;

    logic [DW-1:0] ram [DEPTH];

    int checks = 0;
    int errors = 0;

    int r_first_en, r_first_vld, r_ready_cyc, r_busy_cyc, r_lasts, r_issued_at6;

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_en) mem_rdata <= ram[mem_addr];

    ram_burst_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // mode 0: out_ready held high, 1: random out_ready, 2: out_ready low in cycles T+2..T+6
    task automatic run_burst(input int a, input int l, input int mode);
        int n, idx, issued, c;
        bit done, held_vld, held_last;
        logic [DW-1:0] held_dat;
        n = (l > DEPTH) ? DEPTH : l;
        idx = 0; issued = 0; c = 1; done = 0; held_vld = 0; held_last = 0; held_dat = '0;
        r_first_en = -1; r_first_vld = -1; r_ready_cyc = -1; r_busy_cyc = 0; r_lasts = 0; r_issued_at6 = -1;
        cmd_addr = AW'(a); cmd_len = LW'(l); cmd_valid = 1'b1;
        @(negedge clk);
        check("cmd_ready_before_cmd", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        while (!done && c < 3000) begin
            if (mode == 0) out_ready = 1'b1;
            else if (mode == 1) out_ready = 1'($urandom_range(0, 1));
            else out_ready = !(c >= 2 && c <= 6);
            @(negedge clk);
            if (mem_en) begin
                if (r_first_en < 0) r_first_en = c;
                if (issued < n) check("mem_addr", mem_addr, (a + issued) % DEPTH);
                else check("extra_issue", issued, n);
                issued++;
            end
            if (busy) r_busy_cyc++;
            if (out_valid) begin
                if (r_first_vld < 0) r_first_vld = c;
                if (held_vld) begin
                    check("stall_data", out_data, held_dat);
                    check("stall_last", out_last, held_last);
                end
                if (out_ready) begin
                    if (idx < n) begin
                        check("out_data", out_data, ram[(a + idx) % DEPTH]);
                        check("out_last", out_last, idx == n - 1);
                    end else begin
                        check("extra_word", idx, n);
                    end
                    if (out_last) r_lasts++;
                    idx++;
                end
            end
            check("credit_le2", (issued - idx) <= 2, 1);
            if (c == 6) r_issued_at6 = issued;
            held_vld = out_valid && !out_ready;
            held_dat = out_data;
            held_last = out_last;
            if (cmd_ready) begin
                done = 1;
                r_ready_cyc = c;
            end
            @(posedge clk); #1;
            c++;
        end
        if (!done) check("timeout", 0, 1);
        check("word_count", idx, n);
        check("issue_count", issued, n);
    endtask

    initial begin
        int nonzero, total_lasts, a, l;
        rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) ram[i] = DW'(i + 'h100);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_cmd_ready", cmd_ready, 1);
        check("post_rst_mem_en", mem_en, 0);
        check("post_rst_mem_addr", mem_addr, 0);
        check("post_rst_out_data", out_data, 0);
        check("post_rst_out_last", out_last, 0);
        @(posedge clk); #1;

        // basic burst with latency landmarks
        run_burst(4, 3, 0);
        check("basic_first_en", r_first_en, 1);
        check("basic_first_vld", r_first_vld, 2);
        check("basic_ready_back", r_ready_cyc, 6);
        check("basic_lasts", r_lasts, 1);

        for (int i = 0; i < DEPTH; i++) ram[i] = $urandom;

        run_burst(254, 4, 0);
        check("wrap_lasts", r_lasts, 1);

        run_burst(20, 5, 2);
        check("bp_issued_by_T6", r_issued_at6, 2);
        check("bp_lasts", r_lasts, 1);

        run_burst(7, 0, 0);
        check("zero_busy_cycles", r_busy_cyc, 1);
        check("zero_first_en", r_first_en, -1);
        check("zero_first_vld", r_first_vld, -1);
        check("zero_ready_back", r_ready_cyc, 2);

        run_burst(100, 300, 0);
        check("over_lasts", r_lasts, 1);
        check("over_ready_back", r_ready_cyc, 256 + 3);

        // reset in cycle T+4 of an 8-word burst
        cmd_addr = 8'd10; cmd_len = 9'd8; cmd_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(negedge clk);
        check("midrst_cmd_ready", cmd_ready, 0);
        check("midrst_mem_en", mem_en, 0);
        check("midrst_out_valid", out_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("after_rst_out_valid", out_valid, 0);
        check("after_rst_out_data", out_data, 0);
        check("after_rst_out_last", out_last, 0);
        check("after_rst_mem_en", mem_en, 0);
        check("after_rst_busy", busy, 0);
        check("after_rst_cmd_ready", cmd_ready, 1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("after_rst_idle_valid", out_valid, 0);
        end
        @(posedge clk); #1;
        run_burst(0, 1, 0);
        check("after_rst_single_last", r_lasts, 1);

        // random bursts with random out_ready
        nonzero = 0; total_lasts = 0;
        for (int b = 0; b < 1000; b++) begin
            a = $urandom_range(0, DEPTH - 1);
            if ($urandom_range(0, 49) == 0) l = $urandom_range(200, 300);
            else l = $urandom_range(0, 16);
            run_burst(a, l, 1);
            if (l != 0) nonzero++;
            total_lasts += r_lasts;
        end
        check("rand_last_total", total_lasts, nonzero);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
